// File: rtl/pedal_pkg.sv
// Shared constants for the pedal input stage: bit map of the two pedal
// channels, the released (idle) level, and default timing parameters.
package pedal_pkg;

  typedef logic [1:0] pedal_pair_t;

  localparam int   PEDAL_ACCEL    = 0;
  localparam int   PEDAL_BRAKE    = 1;
  localparam logic PEDAL_RELEASED = 1'b1;

  // 10 ms debounce and 50 ms pressure tick at 50 MHz
  localparam int DEF_DB_CYCLES   = 500000;
  localparam int DEF_RAMP_CYCLES = 2500000;
  localparam int DEF_PRESS_W     = 3;

endpackage

// File: rtl/pedal_conditioner_if.sv
// Pedal conditioner bundle: raw keys in, conditioned pedal levels, pulses
// and pressure out. master = the conditioner, slave = its consumer.
interface pedal_conditioner_if
  import pedal_pkg::*;
#(
  parameter int PRESS_W = DEF_PRESS_W
);

  pedal_pair_t        keys_n;
  pedal_pair_t        pedals;
  logic               accel_press;
  logic               brake_press;
  logic [PRESS_W-1:0] accel_level;
  logic [PRESS_W-1:0] brake_level;
  logic               conflict;

  modport master (
    input  keys_n,
    output pedals, accel_press, brake_press, accel_level, brake_level, conflict
  );

  modport slave (
    output keys_n,
    input  pedals, accel_press, brake_press, accel_level, brake_level, conflict
  );

endinterface

// File: rtl/key_debounce.sv
// One pushbutton channel: 2-flop synchronizer, hold-time debounce and a
// registered one-cycle pulse when the debounced key goes pressed (1->0).
// stable_next exposes the value the stable flop takes on the coming edge so
// the parent can register derived outputs on the same edge.
module key_debounce
  import pedal_pkg::*;
#(
  parameter int DB_CYCLES = DEF_DB_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic stable_next,
  output logic press
);

  localparam int CNT_W = $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;

  // Accept the synced value only after it has differed for DB_CYCLES clocks
  always_comb begin
    sync1_d  = key_n;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    press_d = stable_q & ~stable_d;
  end

  // State registers with synchronous reset to the released state
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= PEDAL_RELEASED;
      sync2_q  <= PEDAL_RELEASED;
      stable_q <= PEDAL_RELEASED;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
    end
  end

  assign stable_next = stable_d;
  assign press       = press_q;

endmodule

// File: rtl/pedal_conditioner.sv
// Pedal conditioner: debounces the accelerator/brake KEYs, drives clean
// active-low pedals for determineRPM, press pulses, saturating pressure
// levels ramped by a shared prescaler tick, and a both-pressed flag.
// Build option BRAKE_PRIORITY_EN: brake overrides the accelerator while
// both are pressed.
module pedal_conditioner
  import pedal_pkg::*;
#(
  parameter int DB_CYCLES   = DEF_DB_CYCLES,
  parameter int RAMP_CYCLES = DEF_RAMP_CYCLES,
  parameter int PRESS_W     = DEF_PRESS_W
) (
  input logic                 clk,
  input logic                 reset,
  pedal_conditioner_if.master pif
);

  localparam int PS_W = $clog2(RAMP_CYCLES);
  localparam logic [PS_W-1:0]    PS_LAST = PS_W'(RAMP_CYCLES - 1);
  localparam logic [PRESS_W-1:0] LVL_MAX = '1;

  pedal_pair_t        stable_next;
  pedal_pair_t        press_raw;
  logic [PS_W-1:0]    presc_q, presc_d;
  logic               tick;
  pedal_pair_t        pedals_q, pedals_d;
  logic               conflict_q, conflict_d;
  logic [PRESS_W-1:0] level_q [2];
  logic [PRESS_W-1:0] level_d [2];
  logic               accel_block;
  logic               accel_press_ok;

  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_accel (
    .clk         (clk),
    .reset       (reset),
    .key_n       (pif.keys_n[PEDAL_ACCEL]),
    .stable_next (stable_next[PEDAL_ACCEL]),
    .press       (press_raw[PEDAL_ACCEL])
  );

  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_brake (
    .clk         (clk),
    .reset       (reset),
    .key_n       (pif.keys_n[PEDAL_BRAKE]),
    .stable_next (stable_next[PEDAL_BRAKE]),
    .press       (press_raw[PEDAL_BRAKE])
  );

`ifdef BRAKE_PRIORITY_EN
  // A pressed brake masks the accelerator; accel presses accepted during a
  // conflict are swallowed so re-engagement after brake release is silent.
  assign accel_block    = ~stable_next[PEDAL_BRAKE];
  assign accel_press_ok = ~conflict_q;
`else
  assign accel_block    = 1'b0;
  assign accel_press_ok = 1'b1;
`endif

  assign tick = (presc_q == PS_LAST);

  // Prescaler wrap, resolved pedal levels and conflict, aligned with stable
  always_comb begin
    presc_d               = tick ? '0 : presc_q + 1'b1;
    conflict_d            = (stable_next == 2'b00);
    pedals_d[PEDAL_BRAKE] = stable_next[PEDAL_BRAKE];
    pedals_d[PEDAL_ACCEL] = stable_next[PEDAL_ACCEL] | accel_block;
  end

  // Pressure levels: one saturating step per tick, up while pressed, else down
  always_comb begin
    for (int ch = 0; ch < 2; ch++) begin
      level_d[ch] = level_q[ch];
      if (tick) begin
        if (pedals_q[ch] != PEDAL_RELEASED) begin
          if (level_q[ch] != LVL_MAX) level_d[ch] = level_q[ch] + 1'b1;
        end else if (level_q[ch] != '0) begin
          level_d[ch] = level_q[ch] - 1'b1;
        end
      end
    end
  end

  // Output and timer registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q    <= '0;
      pedals_q   <= {2{PEDAL_RELEASED}};
      conflict_q <= 1'b0;
      level_q[0] <= '0;
      level_q[1] <= '0;
    end else begin
      presc_q    <= presc_d;
      pedals_q   <= pedals_d;
      conflict_q <= conflict_d;
      level_q[0] <= level_d[0];
      level_q[1] <= level_d[1];
    end
  end

  assign pif.pedals      = pedals_q;
  assign pif.conflict    = conflict_q;
  assign pif.accel_press = press_raw[PEDAL_ACCEL] & accel_press_ok;
  assign pif.brake_press = press_raw[PEDAL_BRAKE];
  assign pif.accel_level = level_q[PEDAL_ACCEL];
  assign pif.brake_level = level_q[PEDAL_BRAKE];

endmodule

// File: tb/tb_pedal_conditioner.sv
// Directed bench for pedal_conditioner with DB_CYCLES=4, RAMP_CYCLES=8,
// PRESS_W=3. cyc counts clock edges since the most recent reset release;
// inputs change and outputs are sampled 1 ns after a rising edge.
module tb_pedal_conditioner;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  pedal_conditioner_if #(.PRESS_W(3)) pif ();

  pedal_conditioner #(
    .DB_CYCLES   (4),
    .RAMP_CYCLES (8),
    .PRESS_W     (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .pif   (pif)
  );

`ifdef BRAKE_PRIORITY_EN
  localparam bit PRI = 1'b1;
`else
  localparam bit PRI = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
    cyc += n;
  endtask

  task automatic step_to(input int c);
    while (cyc < c) step(1);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".pedals"},   32'(pif.pedals), 3);
    chk({tag, ".a_press"},  32'(pif.accel_press), 0);
    chk({tag, ".b_press"},  32'(pif.brake_press), 0);
    chk({tag, ".a_level"},  32'(pif.accel_level), 0);
    chk({tag, ".b_level"},  32'(pif.brake_level), 0);
    chk({tag, ".conflict"}, 32'(pif.conflict), 0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    pif.keys_n = 2'b11;
    reset = 1'b1;
    step(2);
    chk_idle("rst");
    reset = 1'b0;
    cyc = 0;

    // accelerator press at cycle 10 is accepted at 16
    step_to(10);
    pif.keys_n[0] = 1'b0;
    step_to(15);
    chk("acc.pedals_pre", 32'(pif.pedals), 3);
    chk("acc.press_pre",  32'(pif.accel_press), 0);
    step_to(16);
    chk("acc.pedals",     32'(pif.pedals), 2);
    chk("acc.press",      32'(pif.accel_press), 1);
    step_to(17);
    chk("acc.press_1cyc", 32'(pif.accel_press), 0);
    chk("acc.pedals_hold", 32'(pif.pedals), 2);

    // ramp: ticks update levels at edges 8k
    step_to(23); chk("ramp.l23", 32'(pif.accel_level), 0);
    step_to(24); chk("ramp.l24", 32'(pif.accel_level), 1);
    step_to(32); chk("ramp.l32", 32'(pif.accel_level), 2);
    step_to(72); chk("ramp.l72", 32'(pif.accel_level), 7);
    step_to(80); chk("ramp.sat80", 32'(pif.accel_level), 7);
    step_to(88); chk("ramp.sat88", 32'(pif.accel_level), 7);

    // release at 88: pedals high at 94, level decays to 0 by 144
    pif.keys_n[0] = 1'b1;
    step_to(93); chk("rel.pedals_pre", 32'(pif.pedals), 2);
    step_to(94); chk("rel.pedals", 32'(pif.pedals), 3);
    chk("rel.no_press94", 32'(pif.accel_press), 0);
    step_to(95); chk("rel.no_press95", 32'(pif.accel_press), 0);
    step_to(96);  chk("decay.l96", 32'(pif.accel_level), 6);
    step_to(136); chk("decay.l136", 32'(pif.accel_level), 1);
    step_to(144); chk("decay.l144", 32'(pif.accel_level), 0);
    step_to(152); chk("decay.floor", 32'(pif.accel_level), 0);

    // brake bounces every 2 cycles for 20 cycles: never accepted
    for (int c = 152; c <= 180; c++) begin
      step_to(c);
      if (c >= 153) begin
        chk("glitch.pedals", 32'(pif.pedals), 3);
        chk("glitch.press",  32'(pif.brake_press), 0);
      end
      if (c < 172) pif.keys_n[1] = (((c - 152) / 2) % 2) != 0;
      else         pif.keys_n[1] = 1'b1;
    end
    chk("glitch.b_level", 32'(pif.brake_level), 0);

    // accelerator then brake: conflict behaviour
    step_to(184);
    pif.keys_n[0] = 1'b0;
    step_to(190);
    chk("cf.acc_press", 32'(pif.accel_press), 1);
    chk("cf.acc_pedals", 32'(pif.pedals), 2);
    step_to(208); chk("cf.l208", 32'(pif.accel_level), 3);
    step_to(210);
    pif.keys_n[1] = 1'b0;
    step_to(215);
    chk("cf.conflict_pre", 32'(pif.conflict), 0);
    chk("cf.pedals_pre",   32'(pif.pedals), 2);
    step_to(216);
    chk("cf.conflict",     32'(pif.conflict), 1);
    chk("cf.b_press",      32'(pif.brake_press), 1);
    chk("cf.a_press",      32'(pif.accel_press), 0);
    chk("cf.pedals",       32'(pif.pedals), PRI ? 1 : 0);
    chk("cf.a_l216",       32'(pif.accel_level), 4);
    chk("cf.b_l216",       32'(pif.brake_level), 0);
    step_to(224);
    chk("cf.a_l224", 32'(pif.accel_level), PRI ? 3 : 5);
    chk("cf.b_l224", 32'(pif.brake_level), 1);
    step_to(232);
    chk("cf.a_l232", 32'(pif.accel_level), PRI ? 2 : 6);
    chk("cf.b_l232", 32'(pif.brake_level), 2);

    // brake released at 234, accepted at 240; accelerator still held
    step_to(234);
    pif.keys_n[1] = 1'b1;
    step_to(239);
    chk("cf.conflict_hold", 32'(pif.conflict), 1);
    step_to(240);
    chk("rb.conflict", 32'(pif.conflict), 0);
    chk("rb.pedals",   32'(pif.pedals), 2);
    chk("rb.a_press",  32'(pif.accel_press), 0);
    chk("rb.b_press",  32'(pif.brake_press), 0);
    chk("rb.a_l240",   32'(pif.accel_level), PRI ? 1 : 7);
    chk("rb.b_l240",   32'(pif.brake_level), 3);
    step_to(241);
    chk("rb.a_press241", 32'(pif.accel_press), 0);

    // reset held 3 cycles mid-activity
    step_to(244);
    reset = 1'b1;
    pif.keys_n = 2'b11;
    step(1);
    chk_idle("midrst1");
    step(2);
    chk_idle("midrst3");
    reset = 1'b0;
    cyc = 0;

    // accelerator held; reset pulsed at level 5
    pif.keys_n[0] = 1'b0;
    step_to(5); chk("r6.press_pre", 32'(pif.accel_press), 0);
    step_to(6); chk("r6.press",     32'(pif.accel_press), 1);
    step_to(39); chk("r6.l39", 32'(pif.accel_level), 4);
    step_to(40); chk("r6.l40", 32'(pif.accel_level), 5);
    reset = 1'b1;
    step(1);
    chk_idle("r6.rst");
    reset = 1'b0;
    cyc = 0;
    step_to(5);
    chk("r6.re_press_pre", 32'(pif.accel_press), 0);
    chk("r6.re_pedals_pre", 32'(pif.pedals), 3);
    step_to(6);
    chk("r6.re_press", 32'(pif.accel_press), 1);
    chk("r6.re_pedals", 32'(pif.pedals), 2);
    step_to(7);
    chk("r6.re_press_1cyc", 32'(pif.accel_press), 0);
    chk("r6.re_level", 32'(pif.accel_level), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pedal_conditioner.md
Name: pedal_conditioner

Overview:
Upstream input stage between the raw KEY pushbuttons and determineRPM. Synchronizes and debounces the two active-low pedal buttons (accelerator, brake), and emits clean active-low pedal levels as a drop-in for determineRPM's pedals input. Also emits one-cycle press pulses, and saturating "pedal pressure" levels that ramp while a pedal is held. Resolves simultaneous accelerator+brake.

Parameters:
DB_CYCLES, 500000, clocks a synced input must hold a new value before it is accepted (10 ms at 50 MHz); minimum 2
RAMP_CYCLES, 2500000, period of the shared pressure tick (50 ms at 50 MHz); minimum 2
PRESS_W, 3, width of pressure levels; max level = 2^PRESS_W-1

Ports:
clk  input  1  system clock (CLOCK_50)
reset  input  1  synchronous, active-high reset
keys_n  input  2  raw KEY buttons, active-low; [0]=accelerator, [1]=brake; asynchronous to clk
pedals  output  2  debounced/resolved pedals, active-low, same bit map; feeds determineRPM
accel_press  output  1  one-cycle pulse on accepted accelerator press
brake_press  output  1  one-cycle pulse on accepted brake press
accel_level  output  PRESS_W  accelerator pressure, 0..max
brake_level  output  PRESS_W  brake pressure, 0..max
conflict  output  1  high while both debounced pedals are pressed

Behaviour:
- Reset (synchronous, takes effect on the edge where reset=1): sync flops=2'b11; stable=2'b11; debounce counters=0; prescaler=0; pedals=2'b11; press pulses=0; levels=0; conflict=0.
- Sync: 2-flop synchronizer per bit. No logic on the first flop.
- Debounce, per channel: if sync2 equals stable, counter clears to 0. Otherwise the counter increments. On the edge where counter==DB_CYCLES-1 and sync2 still differs, stable takes sync2 and the counter clears.
- Latency: a clean raw edge changes stable exactly DB_CYCLES+2 clocks later. Any glitch shorter than DB_CYCLES synced cycles produces no change.
- Press pulse: registered, high for exactly the one cycle following the edge on which stable goes 1->0. No pulse on release.
- Prescaler: free-running 0..RAMP_CYCLES-1, wraps to 0. Tick is high when prescaler==RAMP_CYCLES-1, first at cycle RAMP_CYCLES-1 after reset release.
- Level update, per channel, on tick only. If effectively pressed: level+1, saturating at max. Else: level-1, saturating at 0. No wrap in either direction.
- Effective press: brake = stable[1]==0. Accelerator = stable[0]==0, subject to the optional feature.
- pedals = registered effective press, active-low; updates on the same edge as stable.
- conflict = registered (stable==2'b00). Asserted regardless of the optional feature.
- Release while a level is nonzero: level decays one step per tick. pedals goes high immediately.
- Reset mid-operation: all state returns to reset values. A key held through reset is re-debounced, and its press pulse fires DB_CYCLES+2 clocks after reset deasserts.

Optional Feature:
BRAKE_PRIORITY_EN
- Defined: while conflict, the accelerator is treated as released. pedals[0]=1, accel_level decays, and no new accel_press is issued until the brake is released and the accelerator is re-accepted. If the accelerator stays held when the brake releases, pedals[0] returns low without a pulse.
- Undefined: both channels pass independently. pedals=2'b00 during conflict, and both levels ramp.

Decomposition:
- Package pedal_pkg: PEDAL_ACCEL=0 and PEDAL_BRAKE=1 bit indices; PEDAL_RELEASED=1'b1; default DB_CYCLES/RAMP_CYCLES constants.
- Sub-module key_debounce, instantiated twice. It holds the synchronizer, counter, stable bit and press pulse, with parameter DB_CYCLES.
- Prescaler, level ramps, priority and conflict logic stay in the top.

Test Plan:
All scenarios use DB_CYCLES=4, RAMP_CYCLES=8, PRESS_W=3.
1. Reset with keys_n=2'b11 -> pedals=2'b11, levels=0, press pulses=0, conflict=0. Hold reset 3 cycles mid-activity -> all outputs back to reset values on the next edge.
2. keys_n[0] 1->0 at cycle 10 and held -> pedals[0] falls at cycle 16; accel_press high for cycle 16 only.
3. keys_n[1] toggles every 2 cycles for 20 cycles, then returns to 1 -> pedals[1] stays 1, no brake_press.
4. Accelerator held 80 cycles -> accel_level steps 1..7, one step per tick, and stays at 7. On release, pedals[0]=1 after 6 cycles and the level decrements to 0 over 7 ticks, never below 0.
5. Both held after acceptance:
   - with BRAKE_PRIORITY_EN: pedals=2'b01, conflict=1, accel_level decays, brake_level ramps.
   - without: pedals=2'b00, conflict=1, both levels ramp.
6. Accelerator held, reset pulsed when accel_level=5 -> level=0 after reset. accel_press fires again 6 cycles after reset deasserts.
